// File: rtl/ro_heater_receiver_if.sv
// ro_heater_receiver_if: strobe/sensor inputs and decoded-word outputs of the RO-heater receiver.
//  master: drives rx_enable, rx_strobe, sensor_valid, sensor_count, sensor_threshold, rx_data_len;
//          observes rx_data, rx_valid, rx_busy, rx_err_count, rx_debug
//  slave : the receiver side (directions mirrored)
interface ro_heater_receiver_if #(
  parameter int MAX_BIT_SIZE = 256,
  parameter int COUNT_W      = 32
);
  localparam int LW = $clog2(MAX_BIT_SIZE) + 1;
  logic                    rx_enable;
  logic                    rx_strobe;
  logic                    sensor_valid;
  logic [COUNT_W-1:0]      sensor_count;
  logic [COUNT_W-1:0]      sensor_threshold;
  logic [LW-1:0]           rx_data_len;
  logic [MAX_BIT_SIZE-1:0] rx_data;
  logic                    rx_valid;
  logic                    rx_busy;
  logic [31:0]             rx_err_count;
  logic [31:0]             rx_debug;
  modport master (
    output rx_enable, rx_strobe, sensor_valid, sensor_count, sensor_threshold, rx_data_len,
    input  rx_data, rx_valid, rx_busy, rx_err_count, rx_debug
  );
  modport slave (
    input  rx_enable, rx_strobe, sensor_valid, sensor_count, sensor_threshold, rx_data_len,
    output rx_data, rx_valid, rx_busy, rx_err_count, rx_debug
  );
endinterface

// File: rtl/ro_heater_receiver.sv
// ro_heater_receiver: votes RO-sensor samples per half-bit window and Manchester-decodes them MSB-first.
//  ro_clk : clock, all logic on posedge
//  rst    : synchronous active-low reset
//  bus    : ro_heater_receiver_if.slave (strobe, sensor samples, frame length in; decoded word and status out)
module ro_heater_receiver #(
  parameter int MAX_BIT_SIZE = 256,
  parameter int COUNT_W      = 32,
  parameter int VOTE_W       = 16
) (
  input logic                 ro_clk,
  input logic                 rst,
  ro_heater_receiver_if.slave bus
);
  localparam int LW = $clog2(MAX_BIT_SIZE) + 1;
  localparam logic [LW-1:0] MAXL = LW'(MAX_BIT_SIZE);
  typedef enum logic [2:0] {IDLE, SAMP1, GAP1, SAMP2, GAP2, DONE, TAIL} state_t;
  state_t                  state_q, state_d;
  logic [LW-1:0]           len_q, len_d, idx_q, idx_d;
  logic [MAX_BIT_SIZE-1:0] shift_q, shift_d, data_q, data_d;
  logic [VOTE_W-1:0]       hot_q, hot_d, cold_q, cold_d, hot_n, cold_n;
  logic [31:0]             err_q, err_d;
  logic [COUNT_W-1:0]      cnt_s, thr_s;
  logic                    h1_q, h1_d, valid_q, valid_d, samp, hot_s, half;
  assign cnt_s = bus.sensor_count;
  assign thr_s = bus.sensor_threshold;
  always_comb begin
    samp    = state_q == SAMP1 || state_q == SAMP2;
    hot_s   = cnt_s < thr_s;
    // votes include a sample coincident with the closing strobe, so resolve on the incremented values
    hot_n   = (samp && bus.sensor_valid && hot_s && ~&hot_q) ? hot_q + 1'b1 : hot_q;
    cold_n  = (samp && bus.sensor_valid && !hot_s && ~&cold_q) ? cold_q + 1'b1 : cold_q;
    half    = hot_n > cold_n;
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    hot_d   = hot_n;
    cold_d  = cold_n;
    h1_d    = h1_q;
    valid_d = 1'b0;
    err_d   = err_q;
    if (!bus.rx_enable) begin
      state_d = IDLE;
      idx_d   = '0;
      shift_d = '0;
      hot_d   = '0;
      cold_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.rx_strobe) begin
          len_d   = (bus.rx_data_len > MAXL) ? MAXL : bus.rx_data_len;
          idx_d   = '0;
          shift_d = '0;
          hot_d   = '0;
          cold_d  = '0;
          state_d = (len_d == '0) ? DONE : SAMP1;
        end
        SAMP1: if (bus.rx_strobe) begin
          h1_d    = half;
          hot_d   = '0;
          cold_d  = '0;
          state_d = GAP1;
        end
        GAP1: if (bus.rx_strobe) state_d = SAMP2;
        SAMP2: if (bus.rx_strobe) begin
          shift_d = {shift_q[MAX_BIT_SIZE-2:0], h1_q & ~half};
          err_d   = (h1_q == half && ~&err_q) ? err_q + 1'b1 : err_q;
          idx_d   = idx_q + 1'b1;
          hot_d   = '0;
          cold_d  = '0;
          state_d = (idx_d == len_q) ? DONE : GAP2;
        end
        GAP2: if (bus.rx_strobe) state_d = SAMP1;
        DONE: begin
          valid_d = 1'b1;
          data_d  = shift_q;
          state_d = TAIL;
        end
        TAIL: if (bus.rx_strobe) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge ro_clk) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      hot_q   <= '0;
      cold_q  <= '0;
      h1_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      hot_q   <= hot_d;
      cold_q  <= cold_d;
      h1_q    <= h1_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_busy      = state_q != IDLE;
  assign bus.rx_err_count = err_q;
  assign bus.rx_debug     = {state_q, 13'b0, 16'(idx_q)};
endmodule

// File: tb/tb_ro_heater_receiver.sv
// tb_ro_heater_receiver: scoreboard bench for ro_heater_receiver driving Manchester frames through the sensor.
module tb_ro_heater_receiver;
  localparam int HOT  = 100;
  localparam int COLD = 200;
  typedef struct {
    logic [255:0] d;
    logic [31:0]  e;
    int           sc;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int   cnt = 0;
  int   ntest = 0;
  int   nfail = 0;
  int   nvalid = 0;
  int   npush = 0;
  int   sc_last = 0;
  logic [31:0] exp_err = '0;
  exp_t q[$];
  exp_t e;
  ro_heater_receiver_if #(.MAX_BIT_SIZE(256), .COUNT_W(32)) bus();
  ro_heater_receiver #(.MAX_BIT_SIZE(256), .COUNT_W(32), .VOTE_W(16)) dut (
    .ro_clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      nvalid++;
      if (q.size() == 0) chk("unexp_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("rx_data", bus.rx_data, e.d);
        chk("rx_err_count", bus.rx_err_count, e.e);
        chk("latency", 256'(cnt - e.sc), 2);
      end
    end
  end
  // k: 0 hot sample, 1 cold sample, 2 no sample
  task automatic cyc(input bit s, input int k);
    bus.rx_strobe    = s;
    bus.sensor_valid = k != 2;
    bus.sensor_count = 32'(k == 0 ? HOT : COLD);
    if (s) sc_last = cnt;
    @(posedge clk);
    #1;
  endtask
  task automatic win_raw(input int pre, input int close);
    repeat (4) cyc(1'b0, pre);
    cyc(1'b1, close);
  endtask
  task automatic win(input bit co, input int k);
    if (co) win_raw(2, k);
    else win_raw(k, 2);
  endtask
  task automatic push(input logic [255:0] d);
    q.push_back('{d, exp_err, sc_last});
    npush++;
  endtask
  // sends nb bits of w (MSB-first); f marks bits whose second half is forced hot
  task automatic frame(input int len, input logic [255:0] w, input logic [255:0] f, input bit co, input int nb);
    int eff, b, k1, k2;
    bit v, fb;
    logic [255:0] d;
    eff = len > 256 ? 256 : len;
    d = '0;
    bus.rx_data_len = 9'(len);
    cyc(1'b1, 2);
    if (eff == 0) push(d);
    for (int i = 0; i < nb; i++) begin
      b  = eff - 1 - i;
      v  = w[b];
      fb = f[b];
      k1 = v ? 0 : 1;
      k2 = (fb || !v) ? 0 : 1;
      win(co, k1);
      win_raw(0, 0);
      win(co, k2);
      d = {d[254:0], v & ~fb};
      if (v && fb) exp_err++;
      if (i == eff - 1) push(d);
      win_raw(0, 0);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [255:0] alt, w;
    alt = {128{2'b10}};
    rst = 1'b0;
    bus.rx_enable = 1'b1;
    bus.rx_strobe = 1'b0;
    bus.sensor_valid = 1'b0;
    bus.sensor_count = '0;
    bus.sensor_threshold = 32'd150;
    bus.rx_data_len = 9'd4;
    cyc(1'b0, 2);
    cyc(1'b0, 2);
    cyc(1'b1, 2);
    rst = 1'b1;
    cyc(1'b0, 2);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_busy", bus.rx_busy, 0);
    chk("rst_data", bus.rx_data, 0);
    chk("rst_err", bus.rx_err_count, 0);
    frame(8, 256'hA5, '0, 1'b0, 8);
    frame(4, 256'hF, 256'h2, 1'b0, 4);
    frame(8, 256'hFF, '0, 1'b0, 3);
    bus.rx_enable = 1'b0;
    cyc(1'b0, 2);
    chk("abort_busy", bus.rx_busy, 0);
    chk("abort_data", bus.rx_data, 256'hD);
    chk("abort_err", bus.rx_err_count, exp_err);
    bus.rx_enable = 1'b1;
    cyc(1'b0, 2);
    frame(0, '0, '0, 1'b0, 0);
    repeat (6) cyc(1'b0, 2);
    chk("tail_busy", bus.rx_busy, 1);
    cyc(1'b1, 2);
    chk("tail_exit", bus.rx_busy, 0);
    frame(8, 256'hFF, '0, 1'b1, 8);
    w = 256'($urandom) & ((256'd1 << 13) - 1);
    frame(13, w, '0, 1'b0, 13);
    w = 256'($urandom);
    frame(32, w, '0, 1'b0, 32);
    frame(300, alt, '0, 1'b0, 256);
    frame(256, ~alt, '0, 1'b0, 100);
    rst = 1'b0;
    cyc(1'b0, 2);
    chk("mid_rst_valid", bus.rx_valid, 0);
    chk("mid_rst_busy", bus.rx_busy, 0);
    chk("mid_rst_data", bus.rx_data, 0);
    chk("mid_rst_err", bus.rx_err_count, 0);
    rst = 1'b1;
    exp_err = '0;
    cyc(1'b0, 2);
    frame(8, 256'h3C, '0, 1'b0, 8);
    repeat (5) cyc(1'b0, 2);
    chk("pending", 256'(q.size()), 0);
    chk("nvalid", 256'(nvalid), 256'(npush));
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
